// File: rtl/booth_r4_mult.sv
// booth_r4_mult -- iterative radix-4 (modified) Booth multiplier.
//
// Retires two multiplier bits per clock. Signed or unsigned operands are
// selected per operation. A start/ready/valid handshake is used, and only
// one operation is in flight at a time.
//
// Parameters:
//   WIDTH        operand width (even, >= 4)
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-high reset
//   start        request, accepted only while ready=1
//   signed_mode  1 = two's complement operands, 0 = unsigned (sampled on accept)
//   mc           multiplicand (sampled on accept)
//   mp           multiplier (sampled on accept)
//   ready        high in IDLE only
//   valid_out    one-cycle pulse, prod has just been updated
//   prod         2*WIDTH-bit product, held until the next valid_out
//
// Optional build macro:
//   BOOTH_EARLY_TERM_EN  finish as soon as every remaining recode is zero
//                        (unconsumed multiplier bits plus Q_1 are uniform).
//                        The result is unchanged; only the latency shrinks.
//                        When this macro is undefined, latency is a fixed
//                        ITER cycles.

module booth_r4_mult #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   mc,
  input  logic [WIDTH-1:0]   mp,
  output logic               ready,
  output logic               valid_out,
  output logic [2*WIDTH-1:0] prod
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int MW   = WIDTH + 2;       // extended multiplicand
  localparam int QW   = WIDTH + 2;       // extended multiplier
  localparam int AW   = WIDTH + 3;       // accumulator, holds +/-2M without overflow
  localparam int TW   = AW + QW + 1;     // {A, Q, Q_1}
  localparam int PW   = 2 * WIDTH;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state, state_next;
  logic [MW-1:0]  m;
  logic [AW-1:0]  a;
  logic [QW-1:0]  q;
  logic           q1;
  logic [CW-1:0]  cnt;

  logic [AW-1:0]  m1, m2, pp, sum;
  logic [TW-1:0]  sh;
  logic           last_iter, early_hit, finish;

  // ---------------------------------------------------------------------------
  // Recode and accumulate
  // ---------------------------------------------------------------------------
  // M and 2M are formed at accumulator width before negation, so -M and
  // -2M never truncate.
  assign m1 = {m[MW-1], m};
  assign m2 = {m, 1'b0};

  always_comb begin
    pp = '0;
    case ({q[1:0], q1})
      3'b001, 3'b010: pp = m1;
      3'b011:         pp = m2;
      3'b100:         pp = -m2;
      3'b101, 3'b110: pp = -m1;
      default:        pp = '0;
    endcase
  end

  assign sum = a + pp;
  assign sh  = $signed({sum, q, q1}) >>> 2;

  assign last_iter = (cnt == CW'(1));

`ifdef BOOTH_EARLY_TERM_EN
  logic any1, all1;

  // The low 2*cnt bits of Q plus Q_1 are the multiplier bits that have not
  // been consumed yet. When they are all equal, every remaining triple is
  // 000 or 111. The remaining work then reduces to a single arithmetic shift.
  // The check is skipped on the first BUSY edge, so at least one real
  // iteration always runs.
  always_comb begin
    any1 = q1;
    all1 = q1;
    for (int unsigned i = 0; i < QW; i++) begin
      if (i < 32'(cnt) * 2) begin
        any1 = any1 | q[i];
        all1 = all1 & q[i];
      end
    end
    early_hit = (cnt != CW'(ITER)) && (!any1 || all1);
  end
`else
  assign early_hit = 1'b0;
`endif

  assign finish = last_iter | early_hit;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)  state_next = BUSY;
      BUSY:    if (finish) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready     = (state == IDLE);
    valid_out = (state == DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      m    <= '0;
      a    <= '0;
      q    <= '0;
      q1   <= 1'b0;
      cnt  <= '0;
      prod <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m   <= signed_mode ? {{2{mc[WIDTH-1]}}, mc} : {2'b00, mc};
            q   <= signed_mode ? {{2{mp[WIDTH-1]}}, mp} : {2'b00, mp};
            a   <= '0;
            q1  <= 1'b0;
            cnt <= CW'(ITER);
          end
        end
        BUSY: begin
`ifdef BOOTH_EARLY_TERM_EN
          if (early_hit) begin
            prod <= PW'($signed({a, q}) >>> {cnt, 1'b0});
            cnt  <= '0;
          end else
`endif
          begin
            {a, q, q1} <= sh;
            cnt        <= cnt - 1'b1;
            // sh[PW:1] is the low 2*WIDTH bits of the shifted {A, Q}.
            if (last_iter) prod <= sh[PW:1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_mult.sv
module tb_booth_r4_mult;

  localparam int W = 16;
`ifdef BOOTH_EARLY_TERM_EN
  localparam int LAT = -1;
`else
  localparam int LAT = 9;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           signed_mode = 1'b0;
  logic [W-1:0]   mc = '0;
  logic [W-1:0]   mp = '0;
  logic           ready;
  logic           valid_out;
  logic [2*W-1:0] prod;

  booth_r4_mult #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .mc          (mc),
    .mp          (mp),
    .ready       (ready),
    .valid_out   (valid_out),
    .prod        (prod)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] p;
    int             acc;
    int             lat;
    string          name;
  } exp_t;

  exp_t           sbq[$];
  exp_t           e;
  int             checks = 0;
  int             failures = 0;
  int             cyc = 0;
  logic [2*W-1:0] held = '0;
  logic           prev_v = 1'b0;

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (reset) begin
      held   = '0;
      prev_v = 1'b0;
    end else begin
      if (prev_v) begin
        checks++;
        if (valid_out !== 1'b0 || ready !== 1'b1) begin
          failures++;
          $display("FAIL pulse_end valid_out=%0b ready=%0b required valid_out=0 ready=1", valid_out, ready);
        end
      end
      if (valid_out) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid prod=%h required no valid_out", prod);
        end else begin
          e = sbq.pop_front();
          if (prod !== e.p) begin
            failures++;
            $display("FAIL %s prod got=%h required=%h", e.name, prod, e.p);
          end
          if (e.lat >= 0) begin
            checks++;
            if (cyc - e.acc != e.lat) begin
              failures++;
              $display("FAIL %s latency got=%0d required=%0d", e.name, cyc - e.acc, e.lat);
            end
          end
        end
        held = prod;
      end else begin
        checks++;
        if (prod !== held) begin
          failures++;
          $display("FAIL prod_hold got=%h required=%h", prod, held);
        end
      end
      prev_v = valid_out;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", nm, got, req);
    end
  endtask

  task automatic push(input string nm, input logic [2*W-1:0] p, input int lat);
    exp_t x;
    x.p    = p;
    x.acc  = cyc + 1;
    x.lat  = lat;
    x.name = nm;
    sbq.push_back(x);
  endtask

  // Called on a falling edge. Inputs are scrambled after the accept edge.
  task automatic issue(input string nm, input logic sm, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2*W-1:0] p, input int lat);
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      failures++;
      $display("FAIL %s ready_timeout ready=%0b required=1", nm, ready);
    end else begin
      signed_mode = sm;
      mc          = a;
      mp          = b;
      start       = 1'b1;
      push(nm, p, lat);
      @(negedge clk);
      start       = 1'b0;
      signed_mode = ~sm;
      mc          = a ^ 16'h5A5A;
      mp          = W'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  logic [W-1:0]   ba[4];
  logic [W-1:0]   bb[4];
  logic           bs[4];
  logic [2*W-1:0] bp[4];

  initial begin
    int last_acc;
    ba[0] = 16'h0002; bb[0] = 16'h0003; bs[0] = 1'b1; bp[0] = 32'h00000006;
    ba[1] = 16'h0010; bb[1] = 16'h0010; bs[1] = 1'b0; bp[1] = 32'h00000100;
    ba[2] = 16'hFFFE; bb[2] = 16'h0004; bs[2] = 1'b1; bp[2] = 32'hFFFFFFF8;
    ba[3] = 16'h0100; bb[3] = 16'h0100; bs[3] = 1'b0; bp[3] = 32'h00010000;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_valid", 32'(valid_out), 32'd0);
    chk("reset_prod", prod, 32'h0);

    issue("s_3_x_m7",      1'b1, 16'h0003, 16'hFFF9, 32'hFFFFFFEB, LAT);
    issue("s_8000_8000",   1'b1, 16'h8000, 16'h8000, 32'h40000000, LAT);
    issue("s_8000_7fff",   1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, LAT);
    issue("u_ffff_ffff",   1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, LAT);
    issue("s_ffff_ffff",   1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, LAT);
    issue("u_1234_5678",   1'b0, 16'h1234, 16'h5678, 32'h06260060, LAT);
    issue("u_0_abcd",      1'b0, 16'h0000, 16'hABCD, 32'h00000000, LAT);
    issue("s_7fff_7fff",   1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF0001, LAT);
    issue("u_8000_8000",   1'b0, 16'h8000, 16'h8000, 32'h40000000, LAT);
    issue("s_5_x_1",       1'b1, 16'h0005, 16'h0001, 32'h00000005, LAT);
    issue("u_ffff_2",      1'b0, 16'hFFFF, 16'h0002, 32'h0001FFFE, LAT);
    issue("s_ffff_2",      1'b1, 16'hFFFF, 16'h0002, 32'hFFFFFFFE, LAT);
`ifdef BOOTH_EARLY_TERM_EN
    issue("et_5_x_1",      1'b0, 16'h0005, 16'h0001, 32'h00000005, 2);
    issue("et_m1_x_m1",    1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, 2);
`endif
    drain();

    // start held high, operands change every cycle
    last_acc = -1;
    for (int k = 0; k < 36; k++) begin
      signed_mode = bs[k % 4];
      mc          = ba[k % 4];
      mp          = bb[k % 4];
      start       = 1'b1;
      if (ready) begin
        push("b2b", bp[k % 4], LAT);
`ifndef BOOTH_EARLY_TERM_EN
        if (last_acc >= 0) chk("b2b_spacing", 32'(cyc + 1 - last_acc), 32'd11);
`endif
        last_acc = cyc + 1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    drain();

    // reset in the middle of an operation
    issue("abort_op", 1'b0, 16'h1234, 16'h5678, 32'h06260060, LAT);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    sbq.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_valid", 32'(valid_out), 32'd0);
    chk("abort_prod", prod, 32'h0);
    issue("after_abort_5x5", 1'b0, 16'h0005, 16'h0005, 32'h00000019, LAT);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
